// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package mips_wb_pkg;

  // Widths of the queued write request; the arbiter's ADDR_W/DATA_W must match these.
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // Register $0 is hard-wired; writes addressed to it never reach the port.
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  // One pending write; valid drops to 0 when a younger pipeline write squashes it.
  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Which source owns the write port in a given cycle.
  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_PIPE,
    GRANT_FIFO
  } grant_e;

endpackage

// File: rtl/wb_pending_fifo.sv
// Circular FIFO holding long-latency results until the write port is free.
// Entries can be invalidated in place by destination when a younger pipeline
// write to the same register wins the port first.
module wb_pending_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  wb_req_t                    pushReq_i,
  input  logic                       pop_i,
  input  logic                       squash_i,
  input  logic [WB_ADDR_W-1:0]       squashDest_i,
  output wb_req_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

  // Advance pointers with explicit wrap so DEPTH need not be a power of two.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (pop_i) begin
      rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
    end
    if (push_i) begin
      wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage update: squash matching entries first so a same-cycle push to that register survives.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_i && (mem_q[i].dest == squashDest_i)) begin
          mem_q[i].valid <= 1'b0;
        end
      end
      if (push_i) begin
        mem_q[wrPtr_q] <= pushReq_i;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Owner of the single register-file write port. The in-order pipeline wins by
// default; long-latency results wait in a small FIFO and a head that waits too
// long forces a one-cycle pipeline stall so it can drain.
module wb_port_arbiter
  import mips_wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = WB_DATA_W,
  parameter int ADDR_W       = WB_ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ip_wb_RegWrite,
  input  logic [ADDR_W-1:0]          ip_wb_dest_reg,
  input  logic [DATA_W-1:0]          ip_wb_data,
  input  logic                       ip_lu_valid,
  input  logic [ADDR_W-1:0]          ip_lu_dest_reg,
  input  logic [DATA_W-1:0]          ip_lu_data,
  output logic                       op_lu_ready,
  output logic                       op_stall,
  output logic                       op_RegWrite,
  output logic [ADDR_W-1:0]          op_dest_reg,
  output logic [DATA_W-1:0]          op_write_data,
  output logic [$clog2(DEPTH+1)-1:0] op_fifo_count
);

  localparam int CTR_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CTR_W-1:0] STARVE_LAST = CTR_W'(STARVE_LIMIT - 1);

  grant_e            grant;
  wb_req_t           fifoHead;
  wb_req_t           luReq;
  logic              fifoFull, fifoEmpty;
  logic              luPush, fifoPop, pipeGrant;

  logic              stall_q, stall_d;
  logic [CTR_W-1:0]  starveCtr_q, starveCtr_d;
  logic              regWrite_q, regWrite_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign op_lu_ready   = reset && !fifoFull;
  assign op_stall      = stall_q;
  assign op_RegWrite   = regWrite_q;
  assign op_dest_reg   = dest_q;
  assign op_write_data = data_q;

  // Results for $0 complete the handshake but are dropped instead of queued.
  assign luPush    = ip_lu_valid && op_lu_ready && (ip_lu_dest_reg != REG_ZERO);
  assign luReq     = '{valid: 1'b1, dest: ip_lu_dest_reg, data: ip_lu_data};
  assign pipeGrant = (grant == GRANT_PIPE);
  assign fifoPop   = (grant == GRANT_FIFO);

  wb_pending_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (luPush),
    .pushReq_i   (luReq),
    .pop_i       (fifoPop),
    .squash_i    (pipeGrant),
    .squashDest_i(ip_wb_dest_reg),
    .head_o      (fifoHead),
    .count_o     (op_fifo_count),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  // Port ownership: a forced stall drains the head, otherwise pipeline first, then FIFO.
  always_comb begin
    grant = GRANT_IDLE;
    if (stall_q) begin
      grant = GRANT_FIFO;
    end else if (ip_wb_RegWrite && (ip_wb_dest_reg != REG_ZERO)) begin
      grant = GRANT_PIPE;
    end else if (!fifoEmpty) begin
      grant = GRANT_FIFO;
    end
  end

  // Next-state for starvation tracking and the registered write port; a squashed head burns its slot silently.
  always_comb begin
    starveCtr_d = (fifoEmpty || fifoPop) ? '0 : starveCtr_q + CTR_W'(1);
    stall_d     = !fifoEmpty && !fifoPop && (starveCtr_q == STARVE_LAST);
    regWrite_d  = 1'b0;
    dest_d      = dest_q;
    data_d      = data_q;
    case (grant)
      GRANT_PIPE: begin
        regWrite_d = 1'b1;
        dest_d     = ip_wb_dest_reg;
        data_d     = ip_wb_data;
      end
      GRANT_FIFO: begin
        if (fifoHead.valid) begin
          regWrite_d = 1'b1;
          dest_d     = fifoHead.dest;
          data_d     = fifoHead.data;
        end
      end
      default: begin
        regWrite_d = 1'b0;
      end
    endcase
  end

  // Arbiter state and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q     <= 1'b0;
      starveCtr_q <= '0;
      regWrite_q  <= 1'b0;
      dest_q      <= '0;
      data_q      <= '0;
    end else begin
      stall_q     <= stall_d;
      starveCtr_q <= starveCtr_d;
      regWrite_q  <= regWrite_d;
      dest_q      <= dest_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed traffic, a queue-based reference model
// checked every cycle, and literal expectations at key points of each scenario.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int CNT_W        = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              wbRegWrite = 1'b0;
  logic [ADDR_W-1:0] wbDest = '0;
  logic [DATA_W-1:0] wbData = '0;
  logic              luValid = 1'b0;
  logic [ADDR_W-1:0] luDest = '0;
  logic [DATA_W-1:0] luData = '0;
  logic              luReady;
  logic              stall;
  logic              regWrite;
  logic [ADDR_W-1:0] destReg;
  logic [DATA_W-1:0] writeData;
  logic [CNT_W-1:0]  fifoCount;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    bit                valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            modelQ[$];
  int                modelStarve = 0;
  bit                modelStall = 1'b0;
  bit                expRegWrite = 1'b0;
  logic [ADDR_W-1:0] expDest = '0;
  logic [DATA_W-1:0] expData = '0;
  bit                modelLive = 1'b0;

  always #5 clock = ~clock;

  wb_port_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ip_wb_RegWrite(wbRegWrite),
    .ip_wb_dest_reg(wbDest),
    .ip_wb_data    (wbData),
    .ip_lu_valid   (luValid),
    .ip_lu_dest_reg(luDest),
    .ip_lu_data    (luData),
    .op_lu_ready   (luReady),
    .op_stall      (stall),
    .op_RegWrite   (regWrite),
    .op_dest_reg   (destReg),
    .op_write_data (writeData),
    .op_fifo_count (fifoCount)
  );

  // Single comparison point shared by the per-cycle model check and the literal checks.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle just past the next rising edge.
  task automatic applyStimulus(input bit rst, input bit wbW, input int wbD, input int wbDat,
                               input bit luV, input int luD, input int luDat);
    @(negedge clock);
    reset      = rst;
    wbRegWrite = wbW;
    wbDest     = ADDR_W'(wbD);
    wbData     = DATA_W'(wbDat);
    luValid    = luV;
    luDest     = ADDR_W'(luD);
    luData     = DATA_W'(luDat);
    @(posedge clock);
    #3;
  endtask

  // Reference model: port ownership decided from a plain queue of pending results.
  always @(posedge clock) begin
    int     cnt;
    bit     pipe;
    bit     doPop;
    bit     nextStall;
    entry_t head;
    if (!reset) begin
      modelQ.delete();
      modelStarve = 0;
      modelStall  = 1'b0;
      expRegWrite = 1'b0;
      expDest     = '0;
      expData     = '0;
      modelLive   = 1'b1;
    end else begin
      cnt   = modelQ.size();
      pipe  = !modelStall && wbRegWrite && (wbDest != 0);
      doPop = modelStall || (!pipe && cnt > 0);
      expRegWrite = 1'b0;
      if (pipe) begin
        expRegWrite = 1'b1;
        expDest     = wbDest;
        expData     = wbData;
        foreach (modelQ[i]) begin
          if (modelQ[i].dest == wbDest) modelQ[i].valid = 1'b0;
        end
      end else if (doPop) begin
        head = modelQ[0];
        if (head.valid) begin
          expRegWrite = 1'b1;
          expDest     = head.dest;
          expData     = head.data;
        end
      end
      nextStall   = (cnt > 0) && !doPop && (modelStarve == STARVE_LIMIT - 1);
      modelStarve = (cnt == 0 || doPop) ? 0 : modelStarve + 1;
      if (doPop) void'(modelQ.pop_front());
      if (luValid && cnt < DEPTH && luDest != 0) begin
        modelQ.push_back('{valid: 1'b1, dest: luDest, data: luData});
      end
      modelStall = nextStall;
    end
  end

  // Every-cycle comparison of the DUT against the reference model.
  always @(posedge clock) begin
    #2;
    if (modelLive) begin
      checkOutput("model_RegWrite", 64'(regWrite), 64'(expRegWrite));
      if (expRegWrite) begin
        checkOutput("model_dest", 64'(destReg), 64'(expDest));
        checkOutput("model_data", 64'(writeData), 64'(expData));
      end
      checkOutput("model_stall", 64'(stall), 64'(modelStall));
      checkOutput("model_count", 64'(fifoCount), 64'(modelQ.size()));
      checkOutput("model_ready", 64'(luReady), 64'(reset && (modelQ.size() < DEPTH)));
    end
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_count", 64'(fifoCount), 64'd0);
    checkOutput("rst_RegWrite", 64'(regWrite), 64'd0);
    checkOutput("rst_ready", 64'(luReady), 64'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_ready_after", 64'(luReady), 64'd1);

    $display("[TB] pipeline-only write");
    applyStimulus(1, 1, 5, 32'h1234, 0, 0, 0);
    checkOutput("t2_RegWrite", 64'(regWrite), 64'd1);
    checkOutput("t2_dest", 64'(destReg), 64'd5);
    checkOutput("t2_data", 64'(writeData), 64'h1234);

    $display("[TB] LLU write with idle pipeline");
    applyStimulus(1, 0, 0, 0, 1, 7, 32'hAA);
    checkOutput("t3_idle_RegWrite", 64'(regWrite), 64'd0);
    checkOutput("t3_hold_dest", 64'(destReg), 64'd5);
    checkOutput("t3_hold_data", 64'(writeData), 64'h1234);
    checkOutput("t3_count1", 64'(fifoCount), 64'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_RegWrite", 64'(regWrite), 64'd1);
    checkOutput("t3_dest", 64'(destReg), 64'd7);
    checkOutput("t3_data", 64'(writeData), 64'hAA);
    checkOutput("t3_count0", 64'(fifoCount), 64'd0);

    $display("[TB] starvation forces one stall");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1, 10 + k, 32'h100 + k, (k == 0), 9, 32'h99);
      checkOutput("t4_stall", 64'(stall), 64'(k == 4));
      checkOutput("t4_pipe_dest", 64'(destReg), 64'(10 + k));
    end
    applyStimulus(1, 1, 15, 32'h105, 0, 0, 0);
    checkOutput("t4_stall_clear", 64'(stall), 64'd0);
    checkOutput("t4_llu_dest", 64'(destReg), 64'd9);
    checkOutput("t4_llu_data", 64'(writeData), 64'h99);
    applyStimulus(1, 1, 15, 32'h105, 0, 0, 0);
    checkOutput("t4_held_dest", 64'(destReg), 64'd15);
    checkOutput("t4_held_data", 64'(writeData), 64'h105);

    $display("[TB] WAW squash");
    applyStimulus(1, 1, 4, 32'h44, 1, 3, 32'h33);
    checkOutput("t5_count1", 64'(fifoCount), 64'd1);
    applyStimulus(1, 1, 3, 32'h55, 0, 0, 0);
    checkOutput("t5_dest", 64'(destReg), 64'd3);
    checkOutput("t5_data", 64'(writeData), 64'h55);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t5_squashed_RegWrite", 64'(regWrite), 64'd0);
    checkOutput("t5_count0", 64'(fifoCount), 64'd0);

    $display("[TB] full FIFO and register zero");
    applyStimulus(1, 1, 20, 32'h2000, 1, 21, 32'h2100);
    applyStimulus(1, 1, 22, 32'h2200, 1, 23, 32'h2300);
    checkOutput("t6_full_count", 64'(fifoCount), 64'd2);
    checkOutput("t6_ready0", 64'(luReady), 64'd0);
    applyStimulus(1, 1, 24, 32'h2400, 1, 0, 32'hDEAD);
    checkOutput("t6_count_held", 64'(fifoCount), 64'd2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_pop1_dest", 64'(destReg), 64'd21);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_pop2_data", 64'(writeData), 64'h2300);
    applyStimulus(1, 1, 0, 32'hBEEF, 1, 0, 32'hDEAD);
    checkOutput("t6_zero_RegWrite", 64'(regWrite), 64'd0);
    checkOutput("t6_zero_count", 64'(fifoCount), 64'd0);

    $display("[TB] reset mid-traffic");
    applyStimulus(1, 1, 28, 32'h2800, 1, 26, 32'h2600);
    applyStimulus(1, 1, 29, 32'h2900, 1, 27, 32'h2700);
    checkOutput("t1_pre_count", 64'(fifoCount), 64'd2);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 1, 30, 32'h3000, 1, 31, 32'h3100);
      checkOutput("t1_count", 64'(fifoCount), 64'd0);
      checkOutput("t1_RegWrite", 64'(regWrite), 64'd0);
      checkOutput("t1_dest", 64'(destReg), 64'd0);
      checkOutput("t1_data", 64'(writeData), 64'd0);
      checkOutput("t1_stall", 64'(stall), 64'd0);
      checkOutput("t1_ready", 64'(luReady), 64'd0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_ready_after", 64'(luReady), 64'd1);
    checkOutput("t1_count_after", 64'(fifoCount), 64'd0);
    checkOutput("t1_RegWrite_after", 64'(regWrite), 64'd0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
